// File: rtl/posit_defines_es3.sv
// Shared ES3 raw-value formats for the multiply/accumulate chain and the accumulator state encoding.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package posit_defines_es3;

  localparam int ABITS = 16;                  // value_sum fraction bits
  localparam int MBITS = 24;                  // value_product fraction bits
  localparam int PSW   = 9;                   // value_product scale width (signed)
  localparam int SSW   = 10;                  // value_sum scale width (signed)
  localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 3 + PSW + MBITS;
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3     = 3 + SSW + ABITS;
  localparam int ACC_SHIFT_MAX = ABITS + 3;   // alignment shift limit; beyond it only sticky survives
  localparam int MW = ABITS + 4;              // mantissa: hidden | fraction | guard | round | sticky

  typedef struct packed {
    logic             zero;
    logic             inf;
    logic             sgn;
    logic [PSW-1:0]   scale;
    logic [MBITS-1:0] fraction;
  } value_product;

  typedef struct packed {
    logic             zero;
    logic             inf;
    logic             sgn;
    logic [SSW-1:0]   scale;
    logic [ABITS-1:0] fraction;
  } value_sum;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} accum_state_t;

  localparam value_sum ACC_ZERO = '{zero: 1'b1, inf: 1'b0, sgn: 1'b0, scale: '0, fraction: '0};

  function automatic logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] serialize_sum(input value_sum v);
    return v;
  endfunction

  function automatic value_product deserialize_prod(input logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] w);
    return value_product'(w);
  endfunction

  // Keep the ABITS most significant product fraction bits, zero-padding when the product is narrower.
  function automatic logic [ABITS-1:0] trunc_frac(input logic [MBITS-1:0] f);
    logic [MBITS+ABITS-1:0] t;
    t = {f, {ABITS{1'b0}}};
    return t[MBITS+ABITS-1 -: ABITS];
  endfunction

endpackage

// File: rtl/posit_lzc.sv
// Leading-zero counter; returns N when the input is all zero.
// Latency: combinational.
// Backpressure: n/a.
module posit_lzc #(
  parameter int N  = 20,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  in,
  output logic [CW-1:0] cnt
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    cnt   = CW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && in[i]) begin
        cnt   = CW'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/positaccum_prod_sum_es3.sv
// Accumulates serialized ES3 value_product terms into a value_sum (align/add/normalize); POSIT_ACCUM_RNE_EN selects RNE in NORM.
// Latency: 3 clk per term after the FIFO pop; done pulses the cycle after the NORM of a last-tagged term.
// Backpressure: ready drops while the IN_DEPTH skid FIFO is full; ready reflects the pre-pop occupancy.
module positaccum_prod_sum_es3
  import posit_defines_es3::*;
#(
  parameter int IN_DEPTH = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] in,
  input  logic                                         start,
  input  logic                                         last,
  output logic                                         ready,
  output logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0]     result,
  output logic                                         done
);

  localparam int PTRW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int PWID = POSIT_SERIALIZED_WIDTH_PRODUCT_ES3;
  localparam int SHW  = $clog2(ACC_SHIFT_MAX + 1);
  localparam int LZW  = $clog2(MW + 1);

  logic [PWID:0]   fifo_mem [IN_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   count;
  logic            push, pop;

  accum_state_t    state, state_nxt;

  value_product    cur;
  logic            cur_last;
  value_sum        acc;

  // ALIGN results
  logic [MW-1:0]   ma, mb;
  logic            sa, sb;
  logic [SSW-1:0]  scale_r;
  logic            byp;
  value_sum        byp_val;
  // ADD results
  logic [MW:0]     sum_m;
  logic            sum_sgn;

  // ALIGN combinational
  logic [SSW-1:0]  t_scale;
  logic signed [SSW:0] diff;
  logic [SSW:0]    mag;
  logic            acc_big;
  logic [SHW-1:0]  sh;
  logic [MW-1:0]   acc_m, term_m, large_m, small_m, small_al, lost_mask;
  logic            byp_c;
  value_sum        byp_val_c;
  // ADD combinational
  logic [MW:0]     sum_c;
  logic            sgn_c;
  // NORM combinational
  logic [LZW-1:0]  lz;
  logic [MW-1:0]   nm;
  logic [SSW-1:0]  nscale;
  logic [ABITS-1:0] frac_n;
  value_sum        norm_val, new_acc;
`ifdef POSIT_ACCUM_RNE_EN
  logic            rnd_up, rnd_c;
`else
  logic            unused_grs;
  assign unused_grs = ^nm[2:0];
`endif

  assign ready = (count != (PTRW+1)'(IN_DEPTH));
  assign push  = start & ready;
  assign pop   = (state_nxt == ALIGN);

  // FIFO storage: last flag travels with its word.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {last, in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: one term per ALIGN/ADD/NORM pass, NORM chains straight into the next term.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|count) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = (|count) ? ALIGN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALIGN: pick the larger-scale operand, shift the other right with sticky, resolve specials.
  always_comb begin
    t_scale  = {{(SSW-PSW){cur.scale[PSW-1]}}, cur.scale};
    diff     = $signed({acc.scale[SSW-1], acc.scale}) - $signed({t_scale[SSW-1], t_scale});
    acc_big  = ~diff[SSW];
    mag      = diff[SSW] ? $unsigned(-diff) : $unsigned(diff);
    sh       = (mag > (SSW+1)'(ACC_SHIFT_MAX)) ? SHW'(ACC_SHIFT_MAX) : mag[SHW-1:0];
    acc_m    = {1'b1, acc.fraction, 3'b000};
    term_m   = {1'b1, trunc_frac(cur.fraction), 3'b000};
    large_m  = acc_big ? acc_m : term_m;
    small_m  = acc_big ? term_m : acc_m;
    lost_mask = (MW'(1) << sh) - MW'(1);
    small_al = (small_m >> sh) | {{(MW-1){1'b0}}, |(small_m & lost_mask)};

    byp_c     = 1'b1;
    byp_val_c = acc;
    if (acc.inf || cur.inf) begin
      byp_val_c.inf  = 1'b1;
      byp_val_c.zero = 1'b0;
    end else if (cur.zero) begin
      byp_val_c = acc;
    end else if (acc.zero) begin
      byp_val_c.zero     = 1'b0;
      byp_val_c.inf      = 1'b0;
      byp_val_c.sgn      = cur.sgn;
      byp_val_c.scale    = t_scale;
      byp_val_c.fraction = trunc_frac(cur.fraction);
    end else begin
      byp_c = 1'b0;
    end
  end

  // ADD: signed-magnitude add; equal magnitudes with opposite signs give +0.
  always_comb begin
    sum_c = '0;
    sgn_c = 1'b0;
    if (sa == sb) begin
      sum_c = {1'b0, ma} + {1'b0, mb};
      sgn_c = sa;
    end else if (ma > mb) begin
      sum_c = {1'b0, ma} - {1'b0, mb};
      sgn_c = sa;
    end else if (mb > ma) begin
      sum_c = {1'b0, mb} - {1'b0, ma};
      sgn_c = sb;
    end
  end

  posit_lzc #(.N(MW)) u_lzc (
    .in  (sum_m[MW-1:0]),
    .cnt (lz)
  );

  // NORM: renormalize on carry or leading zeros, optionally round, then merge the special-case bypass.
  always_comb begin
    nm     = '0;
    nscale = scale_r;
    if (sum_m[MW]) begin
      nm     = sum_m[MW:1] | {{(MW-1){1'b0}}, sum_m[0]};
      nscale = scale_r + SSW'(1);
    end else begin
      nm     = sum_m[MW-1:0] << lz;
      nscale = scale_r - SSW'(lz);
    end
    frac_n = nm[MW-2:3];
`ifdef POSIT_ACCUM_RNE_EN
    rnd_up = nm[2] & (nm[1] | nm[0] | frac_n[0]);
    {rnd_c, frac_n} = {1'b0, frac_n} + {{ABITS{1'b0}}, rnd_up};
    if (rnd_c) nscale = nscale + SSW'(1);
`endif
    norm_val.zero     = 1'b0;
    norm_val.inf      = 1'b0;
    norm_val.sgn      = sum_sgn;
    norm_val.scale    = nscale;
    norm_val.fraction = frac_n;
    if (~|sum_m) norm_val = ACC_ZERO;
    new_acc = byp ? byp_val : norm_val;
    if (new_acc.inf) new_acc.zero = 1'b0;
  end

  // Datapath registers: term fetch, per-stage results, accumulator and result/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= '0;
      cur_last <= 1'b0;
      acc      <= ACC_ZERO;
      ma       <= '0;
      mb       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      scale_r  <= '0;
      byp      <= 1'b0;
      byp_val  <= '0;
      sum_m    <= '0;
      sum_sgn  <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        cur      <= deserialize_prod(fifo_mem[rd_ptr][PWID-1:0]);
        cur_last <= fifo_mem[rd_ptr][PWID];
      end
      case (state)
        ALIGN: begin
          ma      <= large_m;
          mb      <= small_al;
          sa      <= acc_big ? acc.sgn : cur.sgn;
          sb      <= acc_big ? cur.sgn : acc.sgn;
          scale_r <= acc_big ? acc.scale : t_scale;
          byp     <= byp_c;
          byp_val <= byp_val_c;
        end
        ADD: begin
          sum_m   <= sum_c;
          sum_sgn <= sgn_c;
        end
        NORM: begin
          if (cur_last) begin
            result <= serialize_sum(new_acc);
            done   <= 1'b1;
            acc    <= ACC_ZERO;
          end else begin
            acc <= new_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_positaccum_prod_sum_es3.sv
// Directed bench for positaccum_prod_sum_es3: expected sums queued at issue, checked by a done-driven monitor.
// Latency: n/a.
// Backpressure: stimulus waits on ready before each word.
module tb_positaccum_prod_sum_es3;
  import posit_defines_es3::*;

  localparam int PW = POSIT_SERIALIZED_WIDTH_PRODUCT_ES3;
  localparam int SW = POSIT_SERIALIZED_WIDTH_SUM_ES3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          last_w = 1'b0;
  logic [PW-1:0] in_w = '0;
  logic          ready, done;
  logic [SW-1:0] result;

  int            checks = 0;
  int            failures = 0;
  logic [SW-1:0] exp_q [$];
  string         name_q [$];
  logic          watch_nr = 1'b0;
  logic          saw_nr = 1'b0;
  int            lat;

  positaccum_prod_sum_es3 #(.IN_DEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in_w),
    .start  (start),
    .last   (last_w),
    .ready  (ready),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk_prod(input logic z, input logic i, input logic s,
                                            input int sc, input logic [MBITS-1:0] f);
    value_product p;
    p.zero = z; p.inf = i; p.sgn = s; p.scale = sc[PSW-1:0]; p.fraction = f;
    return p;
  endfunction

  function automatic logic [SW-1:0] mk_sum(input logic z, input logic i, input logic s,
                                           input int sc, input logic [ABITS-1:0] f);
    value_sum v;
    v.zero = z; v.inf = i; v.sgn = s; v.scale = sc[SSW-1:0]; v.fraction = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic expect_sum(input string nm, input logic [SW-1:0] w);
    exp_q.push_back(w);
    name_q.push_back(nm);
  endtask

  task automatic push(input logic [PW-1:0] w, input logic l);
    int n;
    @(negedge clk);
    in_w = w; last_w = l; start = 1'b1; n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", ready, 1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%h want=no_done", result);
      end else begin
        logic [SW-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (result !== e) begin
          failures++;
          $display("FAIL %s got=%h want=%h", nm, result, e);
        end
      end
    end
  end

  // Record any cycle where a word was offered but the FIFO was full.
  always @(negedge clk) begin
    if (watch_nr && start && !ready) saw_nr <= 1'b1;
  end

  initial begin
    // 1. reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);

    // 1b. reset while the last term sits in NORM: no done, state discarded
    push(mk_prod(0, 0, 0, 1, 24'h0), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("midreset_result", result, 0);
    chk("midreset_ready", ready, 1);
    expect_sum("after_reset_1p0", mk_sum(0, 0, 0, 0, 16'h0));
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b1);
    drain();

    // 2. 1.0 + 1.0 = 2.0
    expect_sum("t2_one_plus_one", mk_sum(0, 0, 0, 1, 16'h0));
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b1);
    drain();

    // 3. 1.5 - 1.5 = +0, then a fresh 2.0 with latency check
    expect_sum("t3_cancel", mk_sum(1, 0, 0, 0, 16'h0));
    push(mk_prod(0, 0, 0, 0, 24'h800000), 1'b0);
    push(mk_prod(0, 0, 1, 0, 24'h800000), 1'b1);
    drain();
    expect_sum("t3_fresh", mk_sum(0, 0, 0, 1, 16'h0));
    push(mk_prod(0, 0, 0, 1, 24'h0), 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("t3_latency", lat, 4);
    drain();

    // 4a. tiny addend collapses into sticky
    expect_sum("t4_sticky", mk_sum(0, 0, 0, 0, 16'h0));
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, -40, 24'h0), 1'b1);
    drain();

    // 4b. 1.0 + 1.5*2^-16: frac LSB 1 with guard set -> RNE rounds to even
`ifdef POSIT_ACCUM_RNE_EN
    expect_sum("t4_tie", mk_sum(0, 0, 0, 0, 16'h0002));
`else
    expect_sum("t4_tie", mk_sum(0, 0, 0, 0, 16'h0001));
`endif
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, -16, 24'h800000), 1'b1);
    drain();

    // 5. infinity is sticky until done, next sum clean
    expect_sum("t5_inf", mk_sum(0, 1, 0, 0, 16'h0));
    push(mk_prod(0, 1, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, 1, 24'h800000), 1'b1);
    expect_sum("t5_after_inf", mk_sum(0, 0, 0, 0, 16'h0));
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b1);
    drain();

    // 6. streaming: 1+1+1+1 = 4.0 ; 2 + 0.5 - 1 + 0.25 = 1.75
    expect_sum("t6_sum_a", mk_sum(0, 0, 0, 2, 16'h0));
    expect_sum("t6_sum_b", mk_sum(0, 0, 0, 0, 16'hC000));
    watch_nr = 1'b1;
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, 0, 24'h0), 1'b1);
    push(mk_prod(0, 0, 0, 1, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, -1, 24'h0), 1'b0);
    push(mk_prod(0, 0, 1, 0, 24'h0), 1'b0);
    push(mk_prod(0, 0, 0, -2, 24'h0), 1'b1);
    watch_nr = 1'b0;
    chk("t6_ready_dropped", saw_nr, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
